// File: rtl/jts16_sndlatch.sv
`default_nettype none
// ============================================================================
// Module   : jts16_sndlatch
// Purpose  : Main-to-sound CPU command latch. The main CPU writes a command
//            byte and strobes snd_irqn low; the sound CPU is interrupted
//            (snd_nmin low) until it has consumed every pending command by
//            pulsing rd_latch. snd_ack reports an empty buffer back to the
//            main CPU, and overrun records any command that was lost.
//
// Ports    : rst        in   1  asynchronous active-high reset
//            clk        in   1  shared main/sound clock
//            snd_latch  in   8  command byte (main PPI port A)
//            snd_irqn   in   1  command strobe, falling edge = new command
//            sound_en   in   1  sound enable, low flushes the buffer
//            rd_latch   in   1  sound read strobe, rising edge = consume
//            latch_dout out  8  last command handed to the sound CPU
//            snd_nmin   out  1  active-low NMI, low while commands pending
//            snd_ack    out  1  high while the buffer is empty
//            overrun    out  1  sticky lost-command flag
//
// Config   : JTS16_SNDFIFO_EN defined   -> 4-entry FIFO, writes while full
//                                          are dropped.
//            JTS16_SNDFIFO_EN undefined -> single entry, writes while full
//                                          overwrite the pending byte.
//
// Revision : 1.0  initial release
// ============================================================================
module jts16_sndlatch (
  input  logic       rst,
  input  logic       clk,
  input  logic [7:0] snd_latch,
  input  logic       snd_irqn,
  input  logic       sound_en,
  input  logic       rd_latch,
  output logic [7:0] latch_dout,
  output logic       snd_nmin,
  output logic       snd_ack,
  output logic       overrun
);

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------
  logic       snd_irqn_q, snd_irqn_d;
  logic       rd_latch_q, rd_latch_d;
  // armed_q is low for the first clock after reset. Without it, a strobe
  // already sitting at its active level when reset is released would look
  // like an edge against the reset value of the edge-detect register.
  logic       armed_q, armed_d;

  logic       wr_ev;
  logic       rd_ev;

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  logic [7:0] latch_dout_q, latch_dout_d;
  logic       snd_nmin_q, snd_nmin_d;
  logic       snd_ack_q, snd_ack_d;
  logic       overrun_q, overrun_d;

  logic       empty_next;

  always_comb begin
    snd_irqn_d = snd_irqn;
    rd_latch_d = rd_latch;
    armed_d    = 1'b1;
    wr_ev      = armed_q & snd_irqn_q & ~snd_irqn;
    rd_ev      = armed_q & ~rd_latch_q & rd_latch;
  end

`ifdef JTS16_SNDFIFO_EN
  // --------------------------------------------------------------------------
  // 4-entry FIFO storage
  // --------------------------------------------------------------------------
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  logic       do_rd;
  logic       do_wr;
  logic [2:0] count_after_rd;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    latch_dout_d   = latch_dout_q;
    overrun_d      = overrun_q;
    do_rd          = 1'b0;
    do_wr          = 1'b0;
    count_after_rd = count_q;

    if (!sound_en) begin
      wr_ptr_d  = 2'd0;
      rd_ptr_d  = 2'd0;
      count_d   = 3'd0;
      overrun_d = 1'b0;
    end else begin
      // The read is applied to the pre-write contents, so a simultaneous
      // write into a full FIFO lands in the slot the read just vacated.
      do_rd          = rd_ev && (count_q != 3'd0);
      count_after_rd = count_q - {2'b00, do_rd};
      do_wr          = wr_ev && (count_after_rd != 3'd4);

      if (do_rd) begin
        latch_dout_d = mem_q[rd_ptr_q];
        rd_ptr_d     = rd_ptr_q + 2'd1;
      end
      if (do_wr) begin
        mem_d[wr_ptr_q] = snd_latch;
        wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (wr_ev && !do_wr) begin
        overrun_d = 1'b1;
      end
      count_d = count_after_rd + {2'b00, do_wr};
    end

    empty_next = (count_d == 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`else
  // --------------------------------------------------------------------------
  // Single-entry holding register
  // --------------------------------------------------------------------------
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;

  logic       do_rd;
  logic       full_after_rd;

  always_comb begin
    hold_d        = hold_q;
    full_d        = full_q;
    latch_dout_d  = latch_dout_q;
    overrun_d     = overrun_q;
    do_rd         = 1'b0;
    full_after_rd = full_q;

    if (!sound_en) begin
      full_d    = 1'b0;
      overrun_d = 1'b0;
    end else begin
      // A read in the same cycle as a write hands out the old byte first;
      // the new byte then becomes the pending entry without an overrun.
      do_rd         = rd_ev && full_q;
      full_after_rd = full_q & ~do_rd;

      if (do_rd) begin
        latch_dout_d = hold_q;
      end
      if (wr_ev) begin
        hold_d = snd_latch;
        if (full_after_rd) begin
          overrun_d = 1'b1;
        end
      end
      full_d = full_after_rd | wr_ev;
    end

    empty_next = ~full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 8'h00;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

`endif

  // --------------------------------------------------------------------------
  // Status outputs, registered from the next-state occupancy so they change
  // in the same cycle as the buffer contents.
  // --------------------------------------------------------------------------
  always_comb begin
    snd_ack_d  = empty_next;
    snd_nmin_d = ~(~empty_next & sound_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_irqn_q   <= 1'b1;
      rd_latch_q   <= 1'b1;
      armed_q      <= 1'b0;
      latch_dout_q <= 8'h00;
      snd_nmin_q   <= 1'b1;
      snd_ack_q    <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      snd_irqn_q   <= snd_irqn_d;
      rd_latch_q   <= rd_latch_d;
      armed_q      <= armed_d;
      latch_dout_q <= latch_dout_d;
      snd_nmin_q   <= snd_nmin_d;
      snd_ack_q    <= snd_ack_d;
      overrun_q    <= overrun_d;
    end
  end

  assign latch_dout = latch_dout_q;
  assign snd_nmin   = snd_nmin_q;
  assign snd_ack    = snd_ack_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_jts16_sndlatch.sv
`timescale 1ns/1ps
`default_nettype none
module tb_jts16_sndlatch;

  logic       rst, clk, snd_irqn, sound_en, rd_latch;
  logic [7:0] snd_latch, latch_dout;
  logic       snd_nmin, snd_ack, overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

`ifdef JTS16_SNDFIFO_EN
  localparam int CAP  = 4;
  localparam bit FIFO = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit FIFO = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] dout;
    logic       nmin;
    logic       ack;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model: pending commands as a plain queue
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  bit         m_ovr, m_prev_irqn, m_prev_rd, m_armed;

  jts16_sndlatch dut (
    .rst        (rst),
    .clk        (clk),
    .snd_latch  (snd_latch),
    .snd_irqn   (snd_irqn),
    .sound_en   (sound_en),
    .rd_latch   (rd_latch),
    .latch_dout (latch_dout),
    .snd_nmin   (snd_nmin),
    .snd_ack    (snd_ack),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endfunction

  // Monitor: compares every expectation once its clock edge has passed
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check("sb_dout", {24'd0, latch_dout}, {24'd0, mon_e.dout});
      check("sb_nmin", {31'd0, snd_nmin},   {31'd0, mon_e.nmin});
      check("sb_ack",  {31'd0, snd_ack},    {31'd0, mon_e.ack});
      check("sb_ovr",  {31'd0, overrun},    {31'd0, mon_e.ovr});
    end
  end

  function automatic void model_step(input logic irqn, input logic rd,
                                     input logic [7:0] d, input logic en);
    bit w, r;
    w = m_armed && m_prev_irqn && !irqn;
    r = m_armed && !m_prev_rd && rd;
    m_prev_irqn = irqn;
    m_prev_rd   = rd;
    m_armed     = 1'b1;
    if (!en) begin
      mq.delete();
      m_ovr = 1'b0;
    end else begin
      if (r && mq.size() > 0) m_dout = mq.pop_front();
      if (w) begin
        if (mq.size() < CAP) mq.push_back(d);
        else begin
          m_ovr = 1'b1;
          if (!FIFO) mq[0] = d;
        end
      end
    end
  endfunction

  // Drive one cycle of inputs, record the expected post-edge state,
  // return 1ns after that edge.
  task automatic step(input logic irqn, input logic rd, input logic [7:0] d,
                      input logic en);
    exp_t e;
    snd_irqn  = irqn;
    rd_latch  = rd;
    snd_latch = d;
    sound_en  = en;
    model_step(irqn, rd, d, en);
    e.cyc  = cyc + 1;
    e.dout = m_dout;
    e.nmin = !(mq.size() > 0 && en);
    e.ack  = (mq.size() == 0);
    e.ovr  = m_ovr;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic irqn, input logic rd);
    rst = 1'b1;
    sb.delete();
    mq.delete();
    m_dout = 8'h00; m_ovr = 1'b0;
    m_prev_irqn = 1'b1; m_prev_rd = 1'b1; m_armed = 1'b0;
    snd_irqn = irqn; rd_latch = rd; sound_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_dout", {24'd0, latch_dout}, 32'h00);
    check("rst_nmin", {31'd0, snd_nmin},   32'd1);
    check("rst_ack",  {31'd0, snd_ack},    32'd1);
    check("rst_ovr",  {31'd0, overrun},    32'd0);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b0, 1'b0, d, 1'b1);
    step(1'b1, 1'b0, d, 1'b1);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] req);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    check(name, {24'd0, latch_dout}, {24'd0, req});
    step(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; snd_irqn = 1'b1; rd_latch = 1'b0; snd_latch = 8'h00; sound_en = 1'b1;

    // Reset release with the strobe already low: no command
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("rel_nmin", {31'd0, snd_nmin}, 32'd1);
    check("rel_ack",  {31'd0, snd_ack},  32'd1);
    check("rel_dout", {24'd0, latch_dout}, 32'h00);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // Single command round trip
    step(1'b0, 1'b0, 8'h5A, 1'b1);
    check("wr_nmin", {31'd0, snd_nmin}, 32'd0);
    check("wr_ack",  {31'd0, snd_ack},  32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    check("rd_dout", {24'd0, latch_dout}, 32'h5A);
    check("rd_nmin", {31'd0, snd_nmin},   32'd1);
    check("rd_ack",  {31'd0, snd_ack},    32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    // Read on empty buffer leaves everything alone
    rd_chk("rd_empty_dout", 8'h5A);
    check("rd_empty_ovr", {31'd0, overrun}, 32'd0);

`ifdef JTS16_SNDFIFO_EN
    for (int i = 1; i <= 5; i++) wr(i[7:0]);
    check("full_ovr", {31'd0, overrun}, 32'd1);
    for (int i = 1; i <= 4; i++) rd_chk("fifo_dout", i[7:0]);
    check("fifo_empty_ack", {31'd0, snd_ack}, 32'd1);
`else
    wr(8'h11);
    wr(8'h22);
    check("full_ovr", {31'd0, overrun}, 32'd1);
    rd_chk("ovw_dout", 8'h22);
    check("ovw_empty_ack", {31'd0, snd_ack}, 32'd1);
`endif
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // Simultaneous read and write with one entry pending
    wr(8'h33);
    step(1'b0, 1'b1, 8'h44, 1'b1);
    check("simul_dout", {24'd0, latch_dout}, 32'h33);
    check("simul_nmin", {31'd0, snd_nmin},   32'd0);
    check("simul_ack",  {31'd0, snd_ack},    32'd0);
    check("simul_ovr",  {31'd0, overrun},    32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    rd_chk("simul_next", 8'h44);

    // Disable flush with entries pending and overrun set
`ifdef JTS16_SNDFIFO_EN
    for (int i = 0; i < 5; i++) wr(8'hA0 + i[7:0]);
    rd_chk("dis_pre0", 8'hA0);
    rd_chk("dis_pre1", 8'hA1);
    rd_chk("dis_pre2", 8'hA2);
`else
    wr(8'hA0);
    wr(8'hA1);
`endif
    check("dis_pre_ovr",  {31'd0, overrun},  32'd1);
    check("dis_pre_nmin", {31'd0, snd_nmin}, 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("dis_nmin", {31'd0, snd_nmin}, 32'd1);
    check("dis_ack",  {31'd0, snd_ack},  32'd1);
    check("dis_ovr",  {31'd0, overrun},  32'd0);
    step(1'b0, 1'b0, 8'h77, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("dis_wr_ack",  {31'd0, snd_ack},  32'd1);
    check("dis_wr_nmin", {31'd0, snd_nmin}, 32'd1);

    // Reset in the middle of a command strobe: command is lost
    wr(8'h66);
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("midrst_ack",  {31'd0, snd_ack},    32'd1);
    check("midrst_dout", {24'd0, latch_dout}, 32'h00);

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 3) != 0, ($urandom % 3) == 0, 8'($urandom),
           ($urandom % 24) != 0);
    end
    step(1'b1, 1'b0, 8'h00, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
